// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings, FSM states and access-checking helpers for lsu_ctrl
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [2:0] {IDLE, LD_ACC, ST_ACC, RMW_RD, RMW_WR, RESP} lsu_state_e;
  function automatic logic size_misaligned(input logic [2:0] funct3, input logic [1:0] a);
    return funct3[1:0] == 2'b01 ? a[0] : funct3[1:0] == 2'b10 ? |a : 1'b0;
  endfunction
  function automatic logic funct3_legal(input logic store, input logic [2:0] funct3);
    return store ? funct3 inside {F3_B, F3_H, F3_W} : funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction
endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: load lane extract/extend and store lane merge into a read word
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] rd_word,
  input  logic [31:0] merge_word,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] mask, rep;
  always_comb begin
    b = rd_word[{lane, 3'b000} +: 8];
    h = rd_word[{lane[1], 4'b0000} +: 16];
    ld_data = funct3 == F3_B  ? {{24{b[7]}}, b} :
              funct3 == F3_H  ? {{16{h[15]}}, h} :
              funct3 == F3_BU ? {24'b0, b} :
              funct3 == F3_HU ? {16'b0, h} : rd_word;
    // store data is replicated across lanes so the mask alone picks the target bytes
    mask = funct3 == F3_B ? 32'hFF << {lane, 3'b000} :
           funct3 == F3_H ? 32'hFFFF << {lane[1], 4'b0000} : '1;
    rep = funct3 == F3_B ? {4{wdata[7:0]}} : funct3 == F3_H ? {2{wdata[15:0]}} : wdata;
    st_word = (merge_word & ~mask) | (rep & mask);
  end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store sequencer onto a word-wide memory, with RMW for sub-word stores
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rd
);
  if (DATA_W != 32) begin : g_dw_check
    $error("lsu_ctrl: DATA_W must be 32");
  end
  lsu_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, merge_q;
  logic [2:0]        f3_q;
  logic              store_q;
  logic [DATA_W-1:0] ld_data, st_word;
  logic              bad;
  lsu_lane u_lane (
    .funct3    (f3_q),
    .lane      (addr_q[1:0]),
    .rd_word   (mem_rd),
    .merge_word(merge_q),
    .wdata     (wdata_q),
    .ld_data   (ld_data),
    .st_word   (st_word)
  );
  assign bad        = !funct3_legal(req_store, req_funct3) || size_misaligned(req_funct3, req_addr[1:0]);
  assign ready      = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  // gating by rst keeps a reset edge from committing a half-finished write
  assign mem_read   = !rst && (state_q == LD_ACC || state_q == RMW_RD);
  assign mem_write  = !rst && (state_q == ST_ACC || state_q == RMW_WR);
  assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wd     = state_q == ST_ACC ? wdata_q : state_q == RMW_WR ? st_word : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      f3_q       <= '0;
      store_q    <= 1'b0;
      merge_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          f3_q    <= req_funct3;
          store_q <= req_store;
          if (bad) begin
            state_q    <= RESP;
            resp_rdata <= '0;
            resp_err   <= 1'b1;
          end else begin
            state_q <= !req_store ? LD_ACC : req_funct3 == F3_W ? ST_ACC : RMW_RD;
          end
        end
        LD_ACC: begin
          resp_rdata <= ld_data;
          resp_err   <= 1'b0;
          state_q    <= RESP;
        end
        ST_ACC, RMW_WR: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          state_q    <= RESP;
        end
        RMW_RD: begin
          merge_q <= mem_rd;
          state_q <= RMW_WR;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed table, corner sequences and randomized checks of lsu_ctrl against a byte-level model
module tb_lsu_ctrl;
  logic        clk = 0, rst = 1;
  logic        req_valid = 0, req_store = 0;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        ready, resp_valid, resp_err, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_addr, mem_wd, mem_rd;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic        poke_en = 0;
  logic [5:0]  poke_a = 0;
  logic [31:0] poke_d = 0;
  int vectors = 0, errs = 0;

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_store(req_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .ready(ready), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rd(mem_rd)
  );

  assign mem_rd = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[7:2]] <= mem_wd;
    if (poke_en) mem[poke_a] <= poke_d;
  end

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a, wd, rdata;
    logic        err;
    int          lat;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    poke_en = 1; poke_a = a[7:2]; poke_d = d;
    ref_mem[a[7:2]] = d;
    @(negedge clk);
    poke_en = 0;
  endtask

  function automatic logic m_legal(input logic st, input logic [2:0] f3);
    return st ? (f3 == 0 || f3 == 1 || f3 == 2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
  endfunction
  function automatic int m_size(input logic [2:0] f3);
    return f3[1:0] == 0 ? 1 : f3[1:0] == 1 ? 2 : 4;
  endfunction
  function automatic logic m_err(input logic st, input logic [2:0] f3, input logic [31:0] a);
    return !m_legal(st, f3) || (a % m_size(f3)) != 0;
  endfunction
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w, v;
    int sz;
    sz = m_size(f3);
    w  = ref_mem[a[7:2]];
    v  = w >> (8 * a[1:0]);
    if (sz == 1) begin
      v = v & 32'hFF;
      if (!f3[2] && v >= 32'h80) v = v + 32'hFFFFFF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (!f3[2] && v >= 32'h8000) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction
  task automatic m_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] w;
    w = ref_mem[a[7:2]];
    for (int i = 0; i < m_size(f3); i++) w[8*(a[1:0]+i) +: 8] = wd[8*i +: 8];
    ref_mem[a[7:2]] = w;
  endtask

  task automatic do_txn(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input bit hold, output logic [31:0] rd, output logic er, output int lat,
                        output int nr, output int nw, output bit proto);
    @(negedge clk);
    proto = ready && !resp_valid;
    req_valid = 1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    lat = 0; nr = 0; nw = 0;
    do begin
      @(negedge clk);
      lat++;
      if (ready || (mem_read && mem_write)) proto = 0;
      if ((mem_read || mem_write) && mem_addr != {a[31:2], 2'b00}) proto = 0;
      if (mem_read) nr++;
      if (mem_write) nw++;
    end while (!resp_valid && lat < 10);
    rd = resp_rdata; er = resp_err;
    if (!hold) req_valid = 0;
  endtask

  task automatic run_checked(input string nm, input logic st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input bit hold);
    logic [31:0] rd, e_rd;
    logic er, e_er;
    int lat, nr, nw, e_lat;
    bit proto;
    e_er  = m_err(st, f3, a);
    e_lat = e_er ? 1 : (st && m_size(f3) < 4) ? 3 : 2;
    e_rd  = (e_er || st) ? 32'h0 : m_load(f3, a);
    do_txn(st, f3, a, wd, hold, rd, er, lat, nr, nw, proto);
    if (!e_er && st) m_store(f3, a, wd);
    chk({nm, " rdata"}, rd, e_rd);
    chk({nm, " err"}, 32'(er), 32'(e_er));
    chk({nm, " latency"}, 32'(lat), 32'(e_lat));
    chk({nm, " reads"}, 32'(nr), (e_er || (st && m_size(f3) == 4)) ? 0 : 1);
    chk({nm, " writes"}, 32'(nw), (!e_er && st) ? 1 : 0);
    chk({nm, " handshake"}, 32'(proto), 1);
    chk({nm, " mem word"}, mem[a[7:2]], ref_mem[a[7:2]]);
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    int lat, nr, nw;
    bit proto;
    tbl[0]  = '{1'b0, 3'b000, 32'h11, 32'h0,        32'hFFFFFFAA, 1'b0, 2};
    tbl[1]  = '{1'b0, 3'b100, 32'h11, 32'h0,        32'h000000AA, 1'b0, 2};
    tbl[2]  = '{1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFF8899, 1'b0, 2};
    tbl[3]  = '{1'b0, 3'b101, 32'h12, 32'h0,        32'h00008899, 1'b0, 2};
    tbl[4]  = '{1'b0, 3'b010, 32'h10, 32'h0,        32'h8899AABB, 1'b0, 2};
    tbl[5]  = '{1'b1, 3'b000, 32'h22, 32'hDEADBEEF, 32'h0,        1'b0, 3};
    tbl[6]  = '{1'b0, 3'b010, 32'h20, 32'h0,        32'h11EF3344, 1'b0, 2};
    tbl[7]  = '{1'b1, 3'b001, 32'h21, 32'h12345678, 32'h0,        1'b1, 1};
    tbl[8]  = '{1'b0, 3'b010, 32'h20, 32'h0,        32'h11EF3344, 1'b0, 2};
    tbl[9]  = '{1'b0, 3'b011, 32'h20, 32'h0,        32'h0,        1'b1, 1};
    tbl[10] = '{1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF88, 1'b0, 2};
    tbl[11] = '{1'b0, 3'b010, 32'h12, 32'h0,        32'h0,        1'b1, 1};
    tbl[12] = '{1'b1, 3'b001, 32'h22, 32'h1234ABCD, 32'h0,        1'b0, 3};
    tbl[13] = '{1'b0, 3'b010, 32'h20, 32'h0,        32'hABCD3344, 1'b0, 2};
    tbl[14] = '{1'b0, 3'b110, 32'h20, 32'h0,        32'h0,        1'b1, 1};
    tbl[15] = '{1'b1, 3'b100, 32'h20, 32'h55,       32'h0,        1'b1, 1};

    for (int i = 0; i < 64; i++) poke(8'(i * 4), $urandom);
    poke(8'h10, 32'h8899AABB);
    poke(8'h20, 32'h11223344);
    @(negedge clk);
    chk("reset ready", 32'(ready), 1);
    chk("reset resp_valid", 32'(resp_valid), 0);
    chk("reset resp_rdata", resp_rdata, 0);
    chk("reset resp_err", 32'(resp_err), 0);
    chk("reset mem_read", 32'(mem_read), 0);
    chk("reset mem_write", 32'(mem_write), 0);
    rst = 0;

    for (int i = 0; i < 16; i++) begin
      do_txn(tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, 0, rd, er, lat, nr, nw, proto);
      if (!m_err(tbl[i].st, tbl[i].f3, tbl[i].a) && tbl[i].st) m_store(tbl[i].f3, tbl[i].a, tbl[i].wd);
      chk($sformatf("tbl%0d rdata", i), rd, tbl[i].rdata);
      chk($sformatf("tbl%0d err", i), 32'(er), 32'(tbl[i].err));
      chk($sformatf("tbl%0d latency", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("tbl%0d reads", i), 32'(nr), (tbl[i].err || (tbl[i].st && tbl[i].f3 == 3'b010)) ? 0 : 1);
      chk($sformatf("tbl%0d writes", i), 32'(nw), (!tbl[i].err && tbl[i].st) ? 1 : 0);
      chk($sformatf("tbl%0d handshake", i), 32'(proto), 1);
    end
    chk("sh misaligned leaves word", mem[8'h20 >> 2], 32'hABCD3344);

    run_checked("b2b sw", 1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 1);
    run_checked("b2b lw", 1'b0, 3'b010, 32'h30, 32'h0, 0);
    chk("b2b lw data", mem[8'h30 >> 2], 32'hCAFEF00D);

    poke(8'h40, 32'hAAAAAAAA);
    @(negedge clk);
    req_valid = 1; req_store = 1; req_funct3 = 3'b001; req_addr = 32'h40; req_wdata = 32'h5555;
    @(negedge clk);
    chk("rmw_rd read", 32'(mem_read), 1);
    @(negedge clk);
    chk("rmw_wr write", 32'(mem_write), 1);
    rst = 1; req_valid = 0;
    #1 chk("write gated by rst", 32'(mem_write), 0);
    @(negedge clk);
    rst = 0;
    chk("post-rst ready", 32'(ready), 1);
    chk("post-rst resp_valid", 32'(resp_valid), 0);
    chk("post-rst rdata", resp_rdata, 0);
    chk("post-rst err", 32'(resp_err), 0);
    chk("post-rst mem_read", 32'(mem_read), 0);
    chk("post-rst mem_write", 32'(mem_write), 0);
    chk("post-rst mem_addr", mem_addr, 0);
    chk("post-rst mem_wd", mem_wd, 0);
    chk("rst drops write", mem[8'h40 >> 2], 32'hAAAAAAAA);
    @(negedge clk);
    chk("no late resp", 32'(resp_valid), 0);

    for (int i = 0; i < 200; i++)
      run_checked($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  32'($urandom_range(0, 255)), $urandom, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store initiator between the execute stage and the word-addressed data memory. Accepts one RV32I load or store per transaction and sequences it onto the memory's word port. Stores of bytes and halfwords use read-modify-write, because the memory writes whole words only. Loads return sign- or zero-extended data, and the unit drives a ready/response handshake that the pipeline uses as a stall.

Parameters:
ADDR_W, 32, byte-address width on both the request and memory sides
DATA_W, 32, data width; fixed at 32 and checked by an elaboration assertion

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous active-high reset
req_valid  in  1  pipeline presents a load/store
req_store  in  1  1=store, 0=load
req_funct3  in  3  RV32I funct3 of the access
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-aligned
ready  out  1  unit idle; request accepted when req_valid && ready
resp_valid  out  1  one-cycle pulse: transaction complete
resp_rdata  out  DATA_W  extended load result; 0 for stores and errors
resp_err  out  1  valid with resp_valid: misaligned or illegal funct3
mem_addr  out  ADDR_W  address to data memory; bits [1:0] forced 0
mem_wd  out  DATA_W  write word to data memory
mem_read  out  1  memory read enable; read data is combinational
mem_write  out  1  memory write enable; write commits at next posedge
mem_rd  in  DATA_W  memory read data

Behaviour:
- States: IDLE, LD_ACC, ST_ACC, RMW_RD, RMW_WR, RESP.
- On the accept edge, the unit latches addr, wdata, funct3 and store.
- ready = (state==IDLE). The pipeline holds the request stable until resp_valid. req_valid while not ready is ignored.
- Legal loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: funct3 000 SB, 001 SH, 010 SW. Any other funct3 is illegal.
- Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0.
- IDLE transitions on accept:
  - Illegal or misaligned access → RESP with err=1. No memory access is made.
  - Load → LD_ACC.
  - SW → ST_ACC.
  - SB/SH → RMW_RD.
- LD_ACC: mem_read=1. The unit extracts a byte or halfword at lane addr[1:0] from mem_rd, extends it, and registers it into resp_rdata. Next state is RESP.
- ST_ACC: mem_write=1, mem_wd=wdata. Next state is RESP.
- RMW_RD: mem_read=1. The unit registers mem_rd into merge_q. Next state is RMW_WR.
- RMW_WR: mem_write=1. mem_wd = merge_q with only the target lane(s) replaced by wdata[7:0] or wdata[15:0]. Next state is RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. A new request can be accepted the cycle after RESP.
- Latency in cycles from the accept edge to the resp_valid cycle:
  - LW/LB/LH: 2
  - SW: 2
  - SB/SH: 3
  - Error: 1
- mem_read and mem_write are never high together. Both are 0 in IDLE and RESP.
- Outside memory states, mem_addr = {addr_q[ADDR_W-1:2],2'b00} and mem_wd=0.
- Reset state: IDLE; ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_read=0; mem_write=0; merge_q=0.
- Reset mid-operation:
  - mem_write and mem_read are gated by !rst, so no write commits on a reset edge, even in RMW_WR or ST_ACC.
  - The transaction is dropped with no response.
- resp_rdata and resp_err hold their last values until the next RESP. The pipeline samples them only with resp_valid.

Decomposition:
- lsu_pkg holds:
  - the funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the lsu_state_e enum;
  - a function size_misaligned(funct3, addr[1:0]).
- Sub-module lsu_lane (combinational) contains load extract/extend and store lane merge. It is shared by LD_ACC and RMW_WR and unit-tested separately.

Test Plan:
- Preload mem word 0x10 = 0x8899AABB. LB from 0x11 → 0xFFFFFFAA; LBU 0x11 → 0x000000AA; LH 0x12 → 0xFFFF8899. Each gives resp_valid 2 cycles after accept, with err=0.
- Preload mem word 0x20 = 0x11223344. SB addr 0x22, wdata 0xDEADBEEF → one read then one write. The word becomes 0x11EF3344, with resp_valid 3 cycles after accept. A follow-up LW returns 0x11EF3344.
- SH addr 0x21 → resp_err=1 and resp_valid 1 cycle after accept. mem_write and mem_read stay 0 throughout. Memory is unchanged.
- funct3=011 load → resp_err=1 and resp_rdata=0, with no memory access.
- SW 0x30 ← 0xCAFEF00D, immediately followed by LW 0x30 (req_valid held high) → the LW is accepted the cycle after the SW response and returns 0xCAFEF00D. ready is 0 during both transactions except in IDLE.
- Start SH at 0x40, which holds 0xAAAAAAAA. Assert rst in the RMW_WR cycle → no write occurs (word stays 0xAAAAAAAA). No resp_valid is produced. After reset, ready=1 and all outputs are 0.
